// File: rtl/lego_ctrl_pkg.sv
// Shared definitions for the LegoFPGA 4-bit control port. Both the initiator
// (control_nibble_tx) and the receiver side import this package.
//   DEFAULT_SYNC_NIBBLE : first nibble of every frame
//   OP_*                : command opcode constants
//   tx_state_t          : initiator FSM states
//   xor_nibbles()       : frame checksum (XOR of all nibbles of a word)
package lego_ctrl_pkg;

  localparam logic [3:0] DEFAULT_SYNC_NIBBLE = 4'hA;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_RST = 4'h1;
  localparam logic [3:0] OP_RD  = 4'h2;
  localparam logic [3:0] OP_CFG = 4'h3;

  // Checksum input is opcode + payload, zero-extended; zero nibbles do not
  // change an XOR, so one fixed width serves every payload size up to 15.
  localparam int unsigned MAX_CSUM_NIBBLES = 16;
  localparam int unsigned CSUM_W           = 4 * MAX_CSUM_NIBBLES;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_COMMIT = 2'd2
  } tx_state_t;

  function automatic logic [3:0] xor_nibbles(input logic [CSUM_W-1:0] data);
    logic [3:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < MAX_CSUM_NIBBLES; i++) begin
      acc = acc ^ data[4*i +: 4];
    end
    return acc;
  endfunction

endpackage

// File: rtl/control_nibble_tx_if.sv
// Command + control-port bundle for the LegoFPGA control link.
//   cmd_opcode/cmd_payload/cmd_commit/cmd_valid/cmd_ready : host command handshake
//   control_data/control_valid/control_ready              : nibble stream to the board
// master = frame initiator (control_nibble_tx); slave = host/receiver side.
interface control_nibble_tx_if #(
  parameter int unsigned PAYLOAD_NIBBLES = 8
);
  logic [3:0]                   cmd_opcode;
  logic [4*PAYLOAD_NIBBLES-1:0] cmd_payload;
  logic                         cmd_commit;
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [3:0]                   control_data;
  logic                         control_valid;
  logic                         control_ready;

  modport master (
    input  cmd_opcode, cmd_payload, cmd_commit, cmd_valid, control_ready,
    output cmd_ready, control_data, control_valid
  );

  modport slave (
    output cmd_opcode, cmd_payload, cmd_commit, cmd_valid, control_ready,
    input  cmd_ready, control_data, control_valid
  );
endinterface

// File: rtl/ctrl_stall_timer.sv
// Stall watchdog for a valid/ready link.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count (handshake or new frame)
//   stall    : valid high while ready low this cycle
//   expired  : this stall cycle is the TIMEOUT_CYCLES-th consecutive one
// The counter saturates at TIMEOUT_CYCLES so it never wraps if the owner
// keeps stalling after expiry.
module ctrl_stall_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic expired
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (stall && (count != CNT_W'(TIMEOUT_CYCLES))) begin
      count <= count + 1'b1;
    end
  end

  // Flag on the stall that brings the count to TIMEOUT_CYCLES, so the owner
  // can drop valid on the very next cycle.
  assign expired = stall && !clear && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/control_nibble_tx.sv
// Initiator side of the LegoFPGA 4-bit control port. Takes one command per
// handshake and sends it as SYNC, opcode, payload (MSB nibble first),
// checksum; optionally pulses start_config once the frame is accepted.
//   clk_125, sys_rst : clock, synchronous active-high reset
//   bus              : command handshake + nibble stream (master modport)
//   start_config     : one-cycle commit pulse after a committed frame
//   busy             : high outside IDLE
//   timeout_err      : sticky, set when a frame is aborted on a stall timeout
//   frames_sent      : completed frame count, wraps at 16 bits
module control_nibble_tx
  import lego_ctrl_pkg::*;
#(
  parameter int unsigned PAYLOAD_NIBBLES = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter logic [3:0]  SYNC_NIBBLE     = DEFAULT_SYNC_NIBBLE
) (
  input  logic                 clk_125,
  input  logic                 sys_rst,
  control_nibble_tx_if.master  bus,
  output logic                 start_config,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          frames_sent
);
  localparam int unsigned FRAME_NIBBLES = PAYLOAD_NIBBLES + 3;
  localparam int unsigned IDX_W         = $clog2(FRAME_NIBBLES);
  localparam int unsigned PAY_W         = 4 * PAYLOAD_NIBBLES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_NIBBLES - 1);

  tx_state_t        state;
  logic [3:0]       opcode_q;
  logic [PAY_W-1:0] payload_q;
  logic [3:0]       csum_q;
  logic             commit_q;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [3:0]       nibble_nxt;

  logic accept_cmd;
  logic accept_nib;
  logic stall;
  logic stall_clear;
  logic stall_expired;

  assign accept_cmd  = (state == ST_IDLE) && bus.cmd_valid && bus.cmd_ready;
  assign accept_nib  = (state == ST_SEND) && bus.control_valid && bus.control_ready;
  assign stall       = (state == ST_SEND) && bus.control_valid && !bus.control_ready;
  assign stall_clear = accept_cmd || accept_nib;
  assign idx_nxt     = idx + 1'b1;

  // Nibble to present after the current one is accepted. control_data is a
  // register, so the frame is looked up one position ahead.
  always_comb begin
    nibble_nxt = csum_q;
    if (idx_nxt == IDX_W'(1)) begin
      nibble_nxt = opcode_q;
    end
    for (int unsigned k = 0; k < PAYLOAD_NIBBLES; k++) begin
      if (idx_nxt == IDX_W'(k + 2)) begin
        nibble_nxt = payload_q[PAY_W-4-4*k +: 4];
      end
    end
  end

  ctrl_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk     (clk_125),
    .rst     (sys_rst),
    .clear   (stall_clear),
    .stall   (stall),
    .expired (stall_expired)
  );

  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      state             <= ST_IDLE;
      bus.cmd_ready     <= 1'b0;
      bus.control_valid <= 1'b0;
      bus.control_data  <= '0;
      start_config      <= 1'b0;
      busy              <= 1'b0;
      timeout_err       <= 1'b0;
      frames_sent       <= '0;
      idx               <= '0;
      opcode_q          <= '0;
      payload_q         <= '0;
      csum_q            <= '0;
      commit_q          <= 1'b0;
    end else begin
      start_config <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_cmd) begin
            opcode_q          <= bus.cmd_opcode;
            payload_q         <= bus.cmd_payload;
            commit_q          <= bus.cmd_commit;
            csum_q            <= xor_nibbles(CSUM_W'({bus.cmd_opcode, bus.cmd_payload}));
            timeout_err       <= 1'b0;
            idx               <= '0;
            bus.control_data  <= SYNC_NIBBLE;
            bus.control_valid <= 1'b1;
            bus.cmd_ready     <= 1'b0;
            busy              <= 1'b1;
            state             <= ST_SEND;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end

        ST_SEND: begin
          if (accept_nib) begin
            if (idx == LAST_IDX) begin
              bus.control_valid <= 1'b0;
              frames_sent       <= frames_sent + 1'b1;
              if (commit_q) begin
                start_config <= 1'b1;
                state        <= ST_COMMIT;
              end else begin
                bus.cmd_ready <= 1'b1;
                busy          <= 1'b0;
                state         <= ST_IDLE;
              end
            end else begin
              idx              <= idx_nxt;
              bus.control_data <= nibble_nxt;
            end
          end else if (stall_expired) begin
            bus.control_valid <= 1'b0;
            timeout_err       <= 1'b1;
            bus.cmd_ready     <= 1'b1;
            busy              <= 1'b0;
            state             <= ST_IDLE;
          end
        end

        ST_COMMIT: begin
          bus.cmd_ready <= 1'b1;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
